aes_round_controller: RTL and testbench



---
 rtl/aes_round_controller_pkg.sv | 63 ++++++
 rtl/aes_key_step.sv | 35 +++
 rtl/aes_round_controller.sv | 113 +++++++++++
 tb/tb_aes_round_controller.sv | 457 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/aes_round_controller_pkg.sv
// Shared AES-128 types, S-box and round constants for the round controller.
// Optional feature macro used by the top: AES_PERF_CNT_EN.
package aes_round_controller_pkg;

    typedef logic [7:0]   byte_t;
    typedef logic [31:0]  word_t;
    typedef logic [127:0] text_t;

    localparam int FIRST_WORD = 0;
    localparam int LAST_WORD  = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } ctrl_state_e;

    // Index 0 and 11..15 are never used by a legal round; kept zero.
    localparam byte_t RCON [16] = '{
        8'h00, 8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
        8'h80, 8'h1b, 8'h36, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
    };

    localparam byte_t SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5,
        8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0,
        8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc,
        8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a,
        8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0,
        8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b,
        8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85,
        8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5,
        8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17,
        8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88,
        8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c,
        8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9,
        8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6,
        8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e,
        8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94,
        8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68,
        8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    function automatic byte_t sbox(input byte_t b);
        return SBOX[b];
    endfunction

endpackage

// File: rtl/aes_key_step.sv
// Combinational AES-128 next-round-key unit: RotWord, SubWord, Rcon,
// then the chained word XORs.
module aes_key_step
    import aes_round_controller_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  text_t              key,
    input  logic [ROUND_W-1:0] round,
    output text_t              key_next
);

    word_t w [FIRST_WORD:LAST_WORD];
    word_t rot;
    word_t t;
    word_t acc;

    always_comb begin
        key_next = '0;
        for (int i = FIRST_WORD; i <= LAST_WORD; i++) begin
            w[i] = key[127-32*i -: 32];
        end
        rot = {w[LAST_WORD][23:0], w[LAST_WORD][31:24]};
        t = {sbox(rot[31:24]), sbox(rot[23:16]),
             sbox(rot[15:8]),  sbox(rot[7:0])};
        t[31:24] = t[31:24] ^ RCON[round];
        // Each new word folds in the previous new word.
        acc = t;
        for (int i = FIRST_WORD; i <= LAST_WORD; i++) begin
            acc = acc ^ w[i];
            key_next[127-32*i -: 32] = acc;
        end
    end

endmodule

// File: rtl/aes_round_controller.sv
// Iterative AES-128 round sequencer around an external round datapath.
// Optional macro AES_PERF_CNT_EN adds the blk_count completed-block counter.
module aes_round_controller
    import aes_round_controller_pkg::*;
#(
    parameter int NUM_ROUNDS = 10,
    parameter int ROUND_W    = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  text_t              in_text,
    input  text_t              in_key,
    output logic               out_valid,
    input  logic               out_ready,
    output text_t              out_text,
    output logic [ROUND_W-1:0] round,
    output text_t              dp_state,
    input  text_t              dp_result,
`ifdef AES_PERF_CNT_EN
    output logic [31:0]        blk_count,
`endif
    output logic               busy
);

    ctrl_state_e        fsm_q, fsm_d;
    text_t              state_q, state_d;
    text_t              key_q, key_d;
    text_t              rk_next;
    logic [ROUND_W-1:0] round_q, round_d;

    aes_key_step #(
        .ROUND_W (ROUND_W)
    ) u_key_step (
        .key      (key_q),
        .round    (round_q),
        .key_next (rk_next)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            round_q <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            round_q <= round_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        round_d   = round_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_d = in_text ^ in_key;
                    key_d   = in_key;
                    round_d = ROUND_W'(1);
                    fsm_d   = RUN;
                end
            end
            RUN: begin
                busy    = 1'b1;
                state_d = dp_result ^ rk_next;
                key_d   = rk_next;
                if (round_q == ROUND_W'(NUM_ROUNDS)) begin
                    fsm_d = DONE;
                end else begin
                    round_d = round_q + ROUND_W'(1);
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    fsm_d   = IDLE;
                    round_d = '0;
                end
            end
            default: fsm_d = IDLE;
        endcase
    end

    assign round    = round_q;
    assign dp_state = state_q;
    assign out_text = out_valid ? state_q : '0;

`ifdef AES_PERF_CNT_EN
    logic [31:0] blk_count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            blk_count_q <= '0;
        end else if (out_valid && out_ready) begin
            blk_count_q <= blk_count_q + 32'd1;
        end
    end

    assign blk_count = blk_count_q;
`endif

endmodule

// File: tb/tb_aes_round_controller.sv
// Self-checking bench for aes_round_controller with a behavioural AES-128
// model and reference round datapath built from GF(2^8) arithmetic.
module tb_aes_round_controller;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_text;
    logic [127:0] in_key;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_text;
    logic [3:0]   round;
    logic [127:0] dp_state;
    logic [127:0] dp_result;
    logic         busy;
`ifdef AES_PERF_CNT_EN
    logic [31:0]  blk_count;
`endif

    int checks = 0;
    int failures = 0;

    logic [7:0]   sb [256];
    logic [127:0] exp_state [0:10];

    localparam logic [127:0] PT_B  = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] KEY_B = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT_B  = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] PT_C  = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] KEY_C = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT_C  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

    aes_round_controller dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_text   (in_text),
        .in_key    (in_key),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_text  (out_text),
        .round     (round),
        .dp_state  (dp_state),
        .dp_result (dp_result),
`ifdef AES_PERF_CNT_EN
        .blk_count (blk_count),
`endif
        .busy      (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = xtime(a);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    // S-box from the multiplicative inverse plus the affine map.
    task automatic build_sbox();
        logic [7:0] inv;
        sb[0] = 8'h63;
        for (int x = 1; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++) begin
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            end
            sb[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3)
                  ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int i = 0; i < 16; i++) o[127-8*i -: 8] = sb[s[127-8*i -: 8]];
        return o;
    endfunction

    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0] a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] ref_round(input logic [127:0] s, input logic [3:0] r);
        logic [127:0] t;
        t = shift_rows(sub_bytes(s));
        return (r == 4'd10) ? t : mix_columns(t);
    endfunction

    assign dp_result = ref_round(dp_state, round);

    // Full key schedule, then ten rounds; exp_state[r] is the state after round r.
    task automatic model_run(input logic [127:0] pt, input logic [127:0] key,
                             output logic [127:0] ct);
        logic [31:0]  w [0:43];
        logic [31:0]  t;
        logic [7:0]   rc;
        logic [127:0] s;
        for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
        rc = 8'h01;
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {t[23:0], t[31:24]};
                t = {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
                t[31:24] = t[31:24] ^ rc;
                rc = xtime(rc);
            end
            w[i] = w[i-4] ^ t;
        end
        s = pt ^ {w[0], w[1], w[2], w[3]};
        exp_state[0] = s;
        for (int r = 1; r <= 10; r++) begin
            s = ref_round(s, 4'(r)) ^ {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
            exp_state[r] = s;
        end
        ct = s;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        in_text = '0;
        in_key = '0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic send_block(input logic [127:0] pt, input logic [127:0] key,
                              output bit to);
        int n = 0;
        in_text = pt;
        in_key = key;
        in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            @(posedge clk);
            #1;
            n++;
        end
        to = !in_ready;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int cyc, output bit to);
        cyc = 1;
        while (!out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        to = !out_valid;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=100", {in_ready, out_valid, busy});
        end
        checks++;
        if (round !== 4'd0) begin
            failures++;
            $display("FAIL reset_round got=%0d exp=0", round);
        end
        checks++;
        if (dp_state !== '0 || out_text !== '0) begin
            failures++;
            $display("FAIL reset_data dp_state=%h out_text=%h exp=0", dp_state, out_text);
        end
    endtask

    task automatic test_fips_b();
        bit to1, to2;
        int cyc;
        send_block(PT_B, KEY_B, to1);
        wait_valid(cyc, to2);
        checks++;
        if (to1 || to2) begin
            failures++;
            $display("FAIL fips_b_timeout accept_to=%0d valid_to=%0d exp=0", to1, to2);
        end
        checks++;
        if (cyc !== 11) begin
            failures++;
            $display("FAIL fips_b_latency got=%0d exp=11", cyc);
        end
        checks++;
        if (out_text !== CT_B) begin
            failures++;
            $display("FAIL fips_b_ct got=%h exp=%h", out_text, CT_B);
        end
        release_out();
    endtask

    task automatic test_fips_c();
        bit to;
        logic [127:0] ct;
        model_run(PT_C, KEY_C, ct);
        send_block(PT_C, KEY_C, to);
        checks++;
        if (to) begin
            failures++;
            $display("FAIL fips_c_accept timeout");
        end
        for (int r = 1; r <= 10; r++) begin
            checks++;
            if (round !== 4'(r) || busy !== 1'b1 || out_valid !== 1'b0) begin
                failures++;
                $display("FAIL fips_c_round got=%0d busy=%0d ov=%0d exp=%0d 1 0",
                         round, busy, out_valid, r);
            end
            checks++;
            if (dp_state !== exp_state[r-1]) begin
                failures++;
                $display("FAIL fips_c_state r=%0d got=%h exp=%h", r, dp_state, exp_state[r-1]);
            end
            @(posedge clk);
            #1;
        end
        checks++;
        if (out_valid !== 1'b1 || round !== 4'd10) begin
            failures++;
            $display("FAIL fips_c_done ov=%0d round=%0d exp=1 10", out_valid, round);
        end
        checks++;
        if (out_text !== CT_C) begin
            failures++;
            $display("FAIL fips_c_ct got=%h exp=%h", out_text, CT_C);
        end
        release_out();
    endtask

    task automatic test_backpressure();
        bit to1, to2;
        int cyc;
        logic [127:0] pt, key, ct;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_run(pt, key, ct);
        send_block(pt, key, to1);
        wait_valid(cyc, to2);
        checks++;
        if (to1 || to2) begin
            failures++;
            $display("FAIL bp_timeout accept_to=%0d valid_to=%0d", to1, to2);
        end
        in_text = ~pt;
        in_key = ~key;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_text !== ct) begin
                failures++;
                $display("FAIL bp_hold i=%0d ov=%0d ir=%0d ct=%h exp=1 0 %h",
                         i, out_valid, in_ready, out_text, ct);
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        release_out();
        checks++;
        if ({out_valid, in_ready, busy} !== 3'b010 || round !== 4'd0) begin
            failures++;
            $display("FAIL bp_release ov/ir/busy=%b round=%0d exp=010 0",
                     {out_valid, in_ready, busy}, round);
        end
    endtask

    task automatic test_ignore_busy();
        bit to1, to2;
        int cyc;
        logic [127:0] pt, key, ct;
        pt = {$urandom(), $urandom(), $urandom(), $urandom()};
        key = {$urandom(), $urandom(), $urandom(), $urandom()};
        model_run(pt, key, ct);
        send_block(pt, key, to1);
        repeat (3) @(posedge clk);
        #1;
        in_text = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_key = {$urandom(), $urandom(), $urandom(), $urandom()};
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_valid(cyc, to2);
        checks++;
        if (to1 || to2 || out_text !== ct) begin
            failures++;
            $display("FAIL ignore_busy to=%0d%0d got=%h exp=%h", to1, to2, out_text, ct);
        end
        release_out();
    endtask

    task automatic test_mid_reset();
        bit to1, to2;
        int cyc;
        int n = 0;
        send_block(PT_B, KEY_B, to1);
        while (round !== 4'd5 && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (round !== 4'd5) begin
            failures++;
            $display("FAIL midrst_reach round=%0d exp=5", round);
        end
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (round !== 4'd0 || {in_ready, out_valid, busy} !== 3'b100) begin
            failures++;
            $display("FAIL midrst_flags round=%0d ir/ov/busy=%b exp=0 100",
                     round, {in_ready, out_valid, busy});
        end
        checks++;
        if (dp_state !== '0 || out_text !== '0) begin
            failures++;
            $display("FAIL midrst_data dp_state=%h out_text=%h exp=0", dp_state, out_text);
        end
        rst_n = 1'b1;
        send_block(PT_B, KEY_B, to1);
        wait_valid(cyc, to2);
        checks++;
        if (to1 || to2 || cyc !== 11 || out_text !== CT_B) begin
            failures++;
            $display("FAIL midrst_after to=%0d%0d cyc=%0d got=%h exp=11 %h",
                     to1, to2, cyc, out_text, CT_B);
        end
        release_out();
    endtask

    task automatic test_random();
        bit to1, to2;
        int cyc;
        logic [127:0] pt, key, ct;
        for (int k = 0; k < 16; k++) begin
            pt = {$urandom(), $urandom(), $urandom(), $urandom()};
            key = {$urandom(), $urandom(), $urandom(), $urandom()};
            model_run(pt, key, ct);
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
            send_block(pt, key, to1);
            wait_valid(cyc, to2);
            checks++;
            if (to1 || to2 || cyc !== 11 || out_text !== ct) begin
                failures++;
                $display("FAIL rand_ct k=%0d to=%0d%0d cyc=%0d got=%h exp=%h",
                         k, to1, to2, cyc, out_text, ct);
            end
            repeat ($urandom_range(0, 4)) begin
                @(posedge clk);
                #1;
                checks++;
                if (out_valid !== 1'b1 || out_text !== ct) begin
                    failures++;
                    $display("FAIL rand_hold k=%0d ov=%0d got=%h exp=1 %h",
                             k, out_valid, out_text, ct);
                end
            end
            release_out();
        end
    endtask

`ifdef AES_PERF_CNT_EN
    task automatic test_perf_cnt();
        bit to1, to2;
        int cyc;
        apply_reset();
        for (int k = 0; k < 3; k++) begin
            send_block(PT_B, KEY_B, to1);
            wait_valid(cyc, to2);
            release_out();
        end
        checks++;
        if (blk_count !== 32'd3) begin
            failures++;
            $display("FAIL perf_count got=%0d exp=3", blk_count);
        end
        dut.blk_count_q = 32'hffff_ffff;
        send_block(PT_C, KEY_C, to1);
        wait_valid(cyc, to2);
        release_out();
        checks++;
        if (blk_count !== 32'd0) begin
            failures++;
            $display("FAIL perf_wrap got=%h exp=0", blk_count);
        end
    endtask
`endif

    initial begin
        build_sbox();
        test_reset();
        test_fips_b();
        test_fips_c();
        test_backpressure();
        test_ignore_busy();
        test_mid_reset();
        test_random();
`ifdef AES_PERF_CNT_EN
        test_perf_cnt();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
